// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and shadow-stage control type for hazard_ctrl.
// Revision 1.0
`default_nettype none
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 7
    localparam int unsigned CNT_W = 3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_LSTALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_mux.sv
// hazard_fwd_mux: forwarding select for one EX source operand (EX/MEM beats MEM/WB).
// Revision 1.0
`default_nettype none
module hazard_fwd_mux
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              rs_used_i,
    input  stage_ctl_t        exmem_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_wr_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output logic [1:0]        fwd_sel_o
);

    // rs != 0 together with rd == rs also rules out forwarding of x0
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (rs_used_i && (rs_i != '0)) begin
            if (exmem_i.valid && exmem_i.regwrite && !exmem_i.memread && (exmem_rd_i == rs_i)) begin
                fwd_sel_o = FWD_EXMEM;
            end else if (memwb_wr_i && (memwb_rd_i == rs_i)) begin
                fwd_sel_o = FWD_MEMWB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall and branch flush control for the 5-stage core.
// Optional HAZARD_PERF_EN adds stall/flush cycle counters. Revision 1.0
`default_nettype none
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]        id_rs_used_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    input  logic                      mem_pcsrc_i,
    output logic                      stall_pc_o,
    output logic                      stall_ifid_o,
    output logic                      bubble_idex_o,
    output logic                      flush_ifid_o,
    output logic                      flush_idex_o,
    output logic                      flush_exmem_o,
    output logic [NUM_SRC*2-1:0]      fwd_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               stall_count_o,
    output logic [31:0]               flush_count_o
`endif
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

    hz_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    stage_ctl_t                idex_ctl_q, idex_ctl_d;
    logic [REG_AW-1:0]         idex_rd_q, idex_rd_d;
    logic [NUM_SRC*REG_AW-1:0] idex_rs_q, idex_rs_d;
    logic [NUM_SRC-1:0]        idex_rs_used_q, idex_rs_used_d;

    stage_ctl_t                exmem_ctl_q, exmem_ctl_d;
    logic [REG_AW-1:0]         exmem_rd_q, exmem_rd_d;

    logic                      memwb_valid_q, memwb_valid_d;
    logic                      memwb_regwrite_q, memwb_regwrite_d;
    logic [REG_AW-1:0]         memwb_rd_q, memwb_rd_d;

    logic                      w_src_match;
    logic                      w_hazard;
    logic                      w_stall;
    logic                      w_memwb_wr;

    always_comb begin
        w_src_match = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (id_rs_used_i[i] && (id_rs_i[i*REG_AW +: REG_AW] == idex_rd_q)) begin
                w_src_match = 1'b1;
            end
        end
    end

    assign w_hazard = (state_q == ST_RUN) && id_valid_i && idex_ctl_q.valid &&
                      idex_ctl_q.memread && (idex_rd_q != '0) && w_src_match;

    // A taken branch overrides any stall so the redirect PC can load
    assign w_stall = !mem_pcsrc_i && (w_hazard || (state_q == ST_LSTALL));

    assign stall_pc_o    = w_stall;
    assign stall_ifid_o  = w_stall;
    assign bubble_idex_o = w_stall;
    assign flush_ifid_o  = mem_pcsrc_i;
    assign flush_idex_o  = mem_pcsrc_i;
    assign flush_exmem_o = mem_pcsrc_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_pcsrc_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (w_hazard) begin
                cnt_d   = LAT_M1;
                state_d = (LAT_M1 != '0) ? ST_LSTALL : ST_RUN;
            end
        end else begin
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            state_d = (cnt_q <= 1) ? ST_RUN : ST_LSTALL;
        end
    end

    always_comb begin
        if (w_stall || mem_pcsrc_i) begin
            idex_ctl_d     = '0;
            idex_rs_used_d = '0;
        end else begin
            idex_ctl_d.valid    = id_valid_i;
            idex_ctl_d.regwrite = id_valid_i & id_regwrite_i;
            idex_ctl_d.memread  = id_valid_i & id_memread_i;
            idex_rs_used_d      = id_valid_i ? id_rs_used_i : '0;
        end
        idex_rd_d = id_rd_i;
        idex_rs_d = id_rs_i;

        exmem_ctl_d = mem_pcsrc_i ? '0 : idex_ctl_q;
        exmem_rd_d  = idex_rd_q;

        memwb_valid_d    = exmem_ctl_q.valid;
        memwb_regwrite_d = exmem_ctl_q.regwrite;
        memwb_rd_d       = exmem_rd_q;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q          <= ST_RUN;
            cnt_q            <= '0;
            idex_ctl_q       <= '0;
            idex_rd_q        <= '0;
            idex_rs_q        <= '0;
            idex_rs_used_q   <= '0;
            exmem_ctl_q      <= '0;
            exmem_rd_q       <= '0;
            memwb_valid_q    <= 1'b0;
            memwb_regwrite_q <= 1'b0;
            memwb_rd_q       <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            idex_ctl_q       <= idex_ctl_d;
            idex_rd_q        <= idex_rd_d;
            idex_rs_q        <= idex_rs_d;
            idex_rs_used_q   <= idex_rs_used_d;
            exmem_ctl_q      <= exmem_ctl_d;
            exmem_rd_q       <= exmem_rd_d;
            memwb_valid_q    <= memwb_valid_d;
            memwb_regwrite_q <= memwb_regwrite_d;
            memwb_rd_q       <= memwb_rd_d;
        end
    end

    assign w_memwb_wr = memwb_valid_q & memwb_regwrite_q;

    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_fwd
        hazard_fwd_mux #(
            .REG_AW(REG_AW)
        ) u_fwd_mux (
            .rs_i      (idex_rs_q[i*REG_AW +: REG_AW]),
            .rs_used_i (idex_rs_used_q[i]),
            .exmem_i   (exmem_ctl_q),
            .exmem_rd_i(exmem_rd_q),
            .memwb_wr_i(w_memwb_wr),
            .memwb_rd_i(memwb_rd_q),
            .fwd_sel_o (fwd_sel_o[i*2 +: 2])
        );
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    assign stall_count_d = stall_pc_o  ? stall_count_q + 32'd1 : stall_count_q;
    assign flush_count_d = mem_pcsrc_i ? flush_count_q + 32'd1 : flush_count_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count_o = stall_count_q;
    assign flush_count_o = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with LOAD_LAT=1 (dut a) and LOAD_LAT=3 (dut b).
`default_nettype none
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] id_rd;
    logic       id_rw;
    logic       id_mr;
    logic       pcsrc;

    logic       a_stall_pc, a_stall_ifid, a_bubble, a_fl_ifid, a_fl_idex, a_fl_exmem;
    logic [3:0] a_fwd;
    logic       b_stall_pc, b_stall_ifid, b_bubble, b_fl_ifid, b_fl_idex, b_fl_exmem;
    logic [3:0] b_fwd;
`ifdef HAZARD_PERF_EN
    logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

    logic [9:0] a_all, b_all;
    assign a_all = {a_stall_pc, a_stall_ifid, a_bubble, a_fl_ifid, a_fl_idex, a_fl_exmem, a_fwd};
    assign b_all = {b_stall_pc, b_stall_ifid, b_bubble, b_fl_ifid, b_fl_idex, b_fl_exmem, b_fwd};

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) u_dut_a (
        .clock_i(clk), .reset_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
        .id_rs_used_i(id_rs_used), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
        .id_memread_i(id_mr), .mem_pcsrc_i(pcsrc),
        .stall_pc_o(a_stall_pc), .stall_ifid_o(a_stall_ifid), .bubble_idex_o(a_bubble),
        .flush_ifid_o(a_fl_ifid), .flush_idex_o(a_fl_idex), .flush_exmem_o(a_fl_exmem),
        .fwd_sel_o(a_fwd)
`ifdef HAZARD_PERF_EN
        , .stall_count_o(a_scnt), .flush_count_o(a_fcnt)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3)) u_dut_b (
        .clock_i(clk), .reset_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
        .id_rs_used_i(id_rs_used), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
        .id_memread_i(id_mr), .mem_pcsrc_i(pcsrc),
        .stall_pc_o(b_stall_pc), .stall_ifid_o(b_stall_ifid), .bubble_idex_o(b_bubble),
        .flush_ifid_o(b_fl_ifid), .flush_idex_o(b_fl_idex), .flush_exmem_o(b_fl_exmem),
        .fwd_sel_o(b_fwd)
`ifdef HAZARD_PERF_EN
        , .stall_count_o(b_scnt), .flush_count_o(b_fcnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_ins(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] used, input logic [4:0] rd,
                           input logic rw, input logic mr);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        id_rd      = rd;
        id_rw      = rw;
        id_mr      = mr;
    endtask

    task automatic nop();
        set_ins(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain();
        nop();
        pcsrc = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pcsrc = 1'b0;
        nop();
        #3;
        checks++;
        if (a_all !== 10'b0) begin errors++; $display("FAIL reset_a: got %b expected %b", a_all, 10'b0); end
        checks++;
        if (b_all !== 10'b0) begin errors++; $display("FAIL reset_b: got %b expected %b", b_all, 10'b0); end
`ifdef HAZARD_PERF_EN
        checks++;
        if ({a_scnt, a_fcnt} !== 64'd0) begin errors++; $display("FAIL reset_perf: got %h expected 0", {a_scnt, a_fcnt}); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwd_exmem();
        drain();
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);   // add x3,x1,x2
        tick();
        set_ins(1'b1, 5'd3, 5'd5, 2'b11, 5'd4, 1'b1, 1'b0);   // sub x4,x3,x5
        settle();
        checks++;
        if (a_stall_pc !== 1'b0) begin errors++; $display("FAIL exmem_nostall: got %b expected 0", a_stall_pc); end
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0001) begin errors++; $display("FAIL exmem_fwd_a: got %b expected 0001", a_fwd); end
        checks++;
        if (b_fwd !== 4'b0001) begin errors++; $display("FAIL exmem_fwd_b: got %b expected 0001", b_fwd); end
    endtask

    task automatic test_fwd_memwb();
        drain();
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        set_ins(1'b1, 5'd3, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);   // or x6,x3,x1
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0010) begin errors++; $display("FAIL memwb_fwd: got %b expected 0010", a_fwd); end
    endtask

    task automatic test_priority();
        drain();
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        tick();
        set_ins(1'b1, 5'd4, 5'd5, 2'b11, 5'd3, 1'b1, 1'b0);
        tick();
        set_ins(1'b1, 5'd3, 5'd3, 2'b11, 5'd7, 1'b1, 1'b0);
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0101) begin errors++; $display("FAIL priority_fwd: got %b expected 0101", a_fwd); end
    endtask

    task automatic test_x0_and_unused();
        drain();
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0);   // add x0
        tick();
        set_ins(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0);
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0000) begin errors++; $display("FAIL x0_fwd: got %b expected 0000", a_fwd); end
        drain();
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        tick();
        set_ins(1'b1, 5'd3, 5'd3, 2'b10, 5'd9, 1'b1, 1'b0);   // only source 1 is read
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0100) begin errors++; $display("FAIL unused_src_fwd: got %b expected 0100", a_fwd); end
    endtask

    task automatic test_load_use_lat1();
        drain();
        set_ins(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        set_ins(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);   // add x8,x7,x2
        settle();
        checks++;
        if (a_all[9:4] !== 6'b111000) begin errors++; $display("FAIL ll1_stall_c1: got %b expected 111000", a_all[9:4]); end
        tick();
        settle();
        checks++;
        if (a_all[9:7] !== 3'b000) begin errors++; $display("FAIL ll1_stall_c2: got %b expected 000", a_all[9:7]); end
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0010) begin errors++; $display("FAIL ll1_fwd: got %b expected 0010", a_fwd); end
    endtask

    task automatic test_load_use_lat3();
        drain();
        set_ins(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        set_ins(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);
        settle();
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                tick();
                settle();
            end
            checks++;
            if (b_all[9:7] !== 3'b111) begin errors++; $display("FAIL ll3_stall_c%0d: got %b expected 111", k + 1, b_all[9:7]); end
        end
        tick();
        settle();
        checks++;
        if (b_all[9:7] !== 3'b000) begin errors++; $display("FAIL ll3_stall_end: got %b expected 000", b_all[9:7]); end
        tick();
        nop();
        settle();
        checks++;
        if (b_fwd !== 4'b0000) begin errors++; $display("FAIL ll3_fwd: got %b expected 0000", b_fwd); end
    endtask

    task automatic test_branch_during_stall();
        drain();
        set_ins(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        set_ins(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);
        settle();
        checks++;
        if (b_all[9:7] !== 3'b111) begin errors++; $display("FAIL br_stall_c1: got %b expected 111", b_all[9:7]); end
        tick();
        pcsrc = 1'b1;
        settle();
        checks++;
        if (b_all[9:4] !== 6'b000111) begin errors++; $display("FAIL br_stall_flush: got %b expected 000111", b_all[9:4]); end
        tick();
        pcsrc = 1'b0;
        nop();
        settle();
        checks++;
        if (b_all[9:4] !== 6'b000000) begin errors++; $display("FAIL br_stall_run: got %b expected 000000", b_all[9:4]); end
    endtask

    task automatic test_flush_priority();
        drain();
        set_ins(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        set_ins(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);
        pcsrc = 1'b1;
        settle();
        checks++;
        if (a_all[9:4] !== 6'b000111) begin errors++; $display("FAIL flushprio_a: got %b expected 000111", a_all[9:4]); end
        checks++;
        if (b_all[9:4] !== 6'b000111) begin errors++; $display("FAIL flushprio_b: got %b expected 000111", b_all[9:4]); end
        tick();
        pcsrc = 1'b0;
        settle();
        checks++;
        if (b_all[9:7] !== 3'b000) begin errors++; $display("FAIL flushprio_after: got %b expected 000", b_all[9:7]); end
    endtask

    task automatic test_back_to_back();
        drain();
        pcsrc = 1'b1;
        settle();
        checks++;
        if (a_all[6:4] !== 3'b111) begin errors++; $display("FAIL b2b_flush1: got %b expected 111", a_all[6:4]); end
        tick();
        settle();
        checks++;
        if (a_all[6:4] !== 3'b111) begin errors++; $display("FAIL b2b_flush2: got %b expected 111", a_all[6:4]); end
        tick();
        pcsrc = 1'b0;
        settle();
        checks++;
        if (a_all[6:4] !== 3'b000) begin errors++; $display("FAIL b2b_release: got %b expected 000", a_all[6:4]); end
        // The add sits in ID/EX during the flush and must not reach EX/MEM
        drain();
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        tick();
        nop();
        pcsrc = 1'b1;
        tick();
        pcsrc = 1'b0;
        set_ins(1'b1, 5'd3, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        tick();
        nop();
        settle();
        checks++;
        if (a_fwd !== 4'b0000) begin errors++; $display("FAIL squash_fwd: got %b expected 0000", a_fwd); end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_ins(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        set_ins(1'b1, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0);
        tick();
        settle();
        checks++;
        if (b_all[9:7] !== 3'b111) begin errors++; $display("FAIL rst_pre_stall: got %b expected 111", b_all[9:7]); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_all !== 10'b0) begin errors++; $display("FAIL rst_async_b: got %b expected %b", b_all, 10'b0); end
        checks++;
        if (a_all !== 10'b0) begin errors++; $display("FAIL rst_async_a: got %b expected %b", a_all, 10'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        set_ins(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0);
        tick();
        settle();
        checks++;
        if (b_all[9:4] !== 6'b000000) begin errors++; $display("FAIL rst_resume_c1: got %b expected 000000", b_all[9:4]); end
        tick();
        nop();
        settle();
        checks++;
        if (b_all !== 10'b0) begin errors++; $display("FAIL rst_resume_c2: got %b expected %b", b_all, 10'b0); end
    endtask

    initial begin
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_priority();
        test_x0_and_unused();
        test_load_use_lat1();
        test_load_use_lat3();
        test_branch_during_stall();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Keeps its own shadow copy of the destination-register information in flight in ID/EX, EX/MEM and MEM/WB.
- Produces the following controls:
  - operand forwarding selects for the instruction in EX;
  - a load-use stall of parameterised length;
  - a flush of the wrong-path stages when MEM resolves a taken branch (PCSrc).
- Generalises the core from fixed forwarding-free operation to any register-address width, source count and load latency.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- LOAD_LAT, 1, stall cycles needed after a load before a dependent instruction may enter EX (1..7).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  the instruction in ID is real (not a bubble).
- id_rs  in  NUM_SRC*REG_AW  source register addresses of the ID instruction; operand i is bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  per-source "operand is read" flag.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_regwrite  in  1  the ID instruction writes the register file.
- id_memread  in  1  the ID instruction is a load.
- mem_pcsrc  in  1  taken branch resolved in MEM this cycle.
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold the IF/ID register.
- bubble_idex  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- flush_idex  out  1  clear ID/EX.
- flush_exmem  out  1  clear EX/MEM.
- fwd_sel  out  NUM_SRC*2  per EX source: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data.

Behaviour:
- Reset (asynchronous, reset==0):
  - all shadow stages are invalid;
  - FSM is in RUN and the stall counter is 0;
  - all outputs are 0.
- Shadow stages:
  - ID/EX, EX/MEM and MEM/WB each hold {valid, rs[], rs_used, rd, regwrite, memread}.
  - The shadow pipeline advances every cycle.
  - ID/EX loads the ID fields, or a bubble (valid=0) when bubble_idex or flush_idex is asserted.
  - EX/MEM loads a bubble when flush_exmem is asserted.
- Register 0 never produces a hazard and is never forwarded.
- Forwarding is combinational from the shadow state. For each EX source i with rs_used[i] set:
  - select 01 when EX/MEM is valid, EX/MEM regwrite=1, EX/MEM memread=0, EX/MEM rd==rs[i] and rd!=0;
  - otherwise select 10 when MEM/WB is valid, MEM/WB regwrite=1, MEM/WB rd==rs[i] and rd!=0;
  - otherwise select 00.
  - EX/MEM has priority over MEM/WB.
- Load-use detection: in RUN, a hazard exists when all of the following hold:
  - id_valid is set;
  - ID/EX is valid with memread=1 and rd!=0;
  - some used id_rs equals ID/EX rd.
- FSM states RUN and LSTALL:
  - RUN, no hazard: all stall outputs are 0.
  - RUN, hazard detected: stall_pc, stall_ifid and bubble_idex are asserted in the same cycle. The counter loads LOAD_LAT-1. If the loaded value is nonzero, the FSM moves to LSTALL; otherwise it stays in RUN.
  - LSTALL: stall_pc, stall_ifid and bubble_idex stay asserted. The counter decrements each cycle. The FSM returns to RUN the cycle after the counter reaches 0.
  - Total stall length is exactly LOAD_LAT cycles per load-use pair.
- Branch flush:
  - mem_pcsrc=1 asserts flush_ifid, flush_idex and flush_exmem combinationally in the same cycle.
  - Any load stall is cancelled: counter cleared, FSM forced to RUN, and stall_pc/stall_ifid deasserted, so the redirect PC loads.
  - The flush has priority over a simultaneous load-use detection.
- Back-to-back flushes are each honoured independently.
- No output depends combinationally on id_* except stall_pc, stall_ifid and bubble_idex (through hazard detection).

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, two extra outputs are present:
  - stall_count, 32-bit, counts cycles with stall_pc=1;
  - flush_count, 32-bit, counts cycles with mem_pcsrc=1.
- Both counters reset to 0, wrap at 2^32 and saturate never.
- When not defined, these ports and their registers do not exist.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel encodings FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - FSM state encoding ST_RUN/ST_LSTALL;
  - the shadow-stage struct typedef.
- One sub-module, hazard_fwd_mux, evaluates the per-source forwarding select and is instantiated NUM_SRC times.

Test Plan:
- Forwarding case: add x3 then sub x4,x3,x5 -> in the sub's EX cycle fwd_sel[1:0]=01, and no stall.
- Distance-2 case: add x3; nop; or x6,x3,x1 -> fwd_sel[1:0]=10.
- Priority case: add x3 twice back-to-back, then a consumer of x3 -> fwd_sel=01 (newest wins).
- x0 case: add x0 followed by a consumer of x0 -> fwd_sel=00.
- Load-use stall:
  - lw x7 then add x8,x7,x2 with LOAD_LAT=1 -> stall_pc/bubble_idex high for exactly 1 cycle, then fwd_sel=10.
  - Same sequence with LOAD_LAT=3 -> stall for exactly 3 cycles.
- Branch during stall: mem_pcsrc=1 during the 2nd cycle of a LOAD_LAT=3 stall -> all three flush outputs=1 in that cycle, stall_pc=0 that cycle, and RUN on the next cycle.
- Reset mid-stall: reset pulled low during LSTALL -> all outputs 0 immediately (asynchronous), and after release the first non-dependent instruction proceeds with no residual stall.
